// File: rtl/game_pkg.sv
//==============================================================================
// Module  : game_pkg
// Purpose : Shared types and widths for the Warblade game-flow controller.
//           Holds the game state encoding, datapath widths and default frame
//           interval constants.
// Ports   : none (package)
// Config  : GAME_PAUSE_EN (PAUSED encoding is always reserved in the enum)
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package game_pkg;

  localparam int LEVEL_W = 4;
  localparam int LIVES_W = 2;
  localparam int FRAME_W = 8;
  localparam int KILLS_W = 3;

  localparam int DEF_CLEAR_FRAMES = 120;
  localparam int DEF_HIT_FRAMES   = 60;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLAY   = 3'd1,
    CLEAR  = 3'd2,
    HIT    = 3'd3,
    OVER   = 3'd4,
    WIN    = 3'd5,
    PAUSED = 3'd6
  } game_state_e;

endpackage

`default_nettype wire

// File: rtl/rise_edge_det.sv
//==============================================================================
// Module  : rise_edge_det
// Purpose : Registered rising-edge detector. pulse is high for one clock,
//           one clock after din is first sampled high following a low sample.
// Ports   : pclk  in  clock
//           rst   in  asynchronous active-low reset
//           din   in  level input, already synchronous to pclk
//           pulse out registered 1-cycle edge pulse
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module rise_edge_det (
  input  logic pclk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic din_q;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      din_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      din_q <= din;
      pulse <= din & ~din_q;
    end
  end

endmodule

`default_nettype wire

// File: rtl/game_sequencer.sv
//==============================================================================
// Module  : game_sequencer
// Purpose : Frame-synchronous game-flow controller. Counts kills and hits and
//           sequences IDLE -> PLAY -> CLEAR -> next level / OVER / WIN.
//           Timed intervals are counted in frames (vsync_in rising edges).
// Ports   : pclk         in   pixel clock
//           rst          in   asynchronous active-low reset
//           vsync_in     in   vsync; rising edge is the frame tick
//           start        in   start/restart button (rising edge used)
//           enemy_killed in   1-cycle pulse per enemy destroyed
//           player_hit   in   1-cycle pulse per hit on the player
//           pause        in   pause button (only with GAME_PAUSE_EN)
//           level        out  current level 1..NUM_LEVELS
//           level_change out  1-cycle pulse on level load/advance
//           lives        out  remaining lives
//           state        out  encoded game state (game_state_e)
//           play_en      out  high only in PLAY
//           freeze       out  high whenever not in PLAY
// Config  : GAME_PAUSE_EN - adds the pause input and the PAUSED state
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module game_sequencer
  import game_pkg::*;
#(
  parameter int NUM_LEVELS    = 8,
  parameter int KILLS_PER_LVL = 5,
  parameter int LIVES_INIT    = 3,
  parameter int CLEAR_FRAMES  = DEF_CLEAR_FRAMES,
  parameter int HIT_FRAMES    = DEF_HIT_FRAMES
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               vsync_in,
  input  logic               start,
  input  logic               enemy_killed,
  input  logic               player_hit,
`ifdef GAME_PAUSE_EN
  input  logic               pause,
`endif
  output logic [LEVEL_W-1:0] level,
  output logic               level_change,
  output logic [LIVES_W-1:0] lives,
  output logic [2:0]         state,
  output logic               play_en,
  output logic               freeze
);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(NUM_LEVELS);
  localparam logic [KILLS_W-1:0] KILLS_TGT = KILLS_W'(KILLS_PER_LVL);
  localparam logic [LIVES_W-1:0] LIVES_LD  = LIVES_W'(LIVES_INIT);
  localparam logic [FRAME_W-1:0] CLEAR_LD  = FRAME_W'(CLEAR_FRAMES);
  localparam logic [FRAME_W-1:0] HIT_LD    = FRAME_W'(HIT_FRAMES);

  game_state_e        cur;
  logic [KILLS_W-1:0] kills;
  logic [FRAME_W-1:0] frame_cnt;
  logic               frame_tick;
  logic               start_edge;
  logic               pause_edge;

  rise_edge_det u_vsync_edge (.pclk(pclk), .rst(rst), .din(vsync_in), .pulse(frame_tick));
  rise_edge_det u_start_edge (.pclk(pclk), .rst(rst), .din(start),    .pulse(start_edge));

`ifdef GAME_PAUSE_EN
  rise_edge_det u_pause_edge (.pclk(pclk), .rst(rst), .din(pause),    .pulse(pause_edge));
`else
  // No pause button: PAUSED is unreachable.
  assign pause_edge = 1'b0;
`endif

  assign state = cur;

  // play_en/freeze are written alongside every state change so they stay
  // registered and aligned with state.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      cur          <= IDLE;
      level        <= LEVEL_W'(1);
      lives        <= LIVES_LD;
      kills        <= '0;
      frame_cnt    <= '0;
      level_change <= 1'b0;
      play_en      <= 1'b0;
      freeze       <= 1'b1;
    end else begin
      level_change <= 1'b0;
      case (cur)
        IDLE, OVER, WIN: begin
          if (start_edge) begin
            cur          <= PLAY;
            play_en      <= 1'b1;
            freeze       <= 1'b0;
            level        <= LEVEL_W'(1);
            lives        <= LIVES_LD;
            kills        <= '0;
            frame_cnt    <= '0;
            level_change <= 1'b1;
          end
        end

        PLAY: begin
          if (pause_edge) begin
            cur     <= PAUSED;
            play_en <= 1'b0;
            freeze  <= 1'b1;
          end else if (player_hit) begin
            // A hit wins over a simultaneous kill; the kill is dropped.
            play_en <= 1'b0;
            freeze  <= 1'b1;
            if (lives <= LIVES_W'(1)) begin
              lives <= '0;
              cur   <= OVER;
            end else begin
              lives     <= lives - LIVES_W'(1);
              cur       <= HIT;
              frame_cnt <= HIT_LD;
            end
          end else if (enemy_killed) begin
            if (kills >= KILLS_TGT - KILLS_W'(1)) begin
              kills     <= KILLS_TGT;
              cur       <= CLEAR;
              frame_cnt <= CLEAR_LD;
              play_en   <= 1'b0;
              freeze    <= 1'b1;
            end else begin
              kills <= kills + KILLS_W'(1);
            end
          end
        end

        CLEAR: begin
          if (frame_tick) begin
            // Leaving on the tick that would reach zero gives exactly
            // CLEAR_FRAMES ticks in this state.
            if (frame_cnt <= FRAME_W'(1)) begin
              frame_cnt <= '0;
              if (level >= LEVEL_MAX) begin
                cur <= WIN;
              end else begin
                level        <= level + LEVEL_W'(1);
                kills        <= '0;
                level_change <= 1'b1;
                cur          <= PLAY;
                play_en      <= 1'b1;
                freeze       <= 1'b0;
              end
            end else begin
              frame_cnt <= frame_cnt - FRAME_W'(1);
            end
          end
        end

        HIT: begin
          if (frame_tick) begin
            if (frame_cnt <= FRAME_W'(1)) begin
              frame_cnt <= '0;
              cur       <= PLAY;
              play_en   <= 1'b1;
              freeze    <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt - FRAME_W'(1);
            end
          end
        end

        PAUSED: begin
          if (pause_edge) begin
            cur     <= PLAY;
            play_en <= 1'b1;
            freeze  <= 1'b0;
          end
        end

        default: begin
          cur     <= IDLE;
          play_en <= 1'b0;
          freeze  <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
//==============================================================================
// Module  : tb_game_sequencer
// Purpose : Self-checking bench for game_sequencer. A table of directed
//           vectors covers start/kill/hit/frame sequences; hand-written
//           sequences cover the full 8-level run, async reset and pause.
// Config  : GAME_PAUSE_EN - enables the pause port and its sequence
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_game_sequencer;
  import game_pkg::*;

  logic       pclk = 1'b0;
  logic       rst = 1'b0;
  logic       vsync_in = 1'b0;
  logic       start = 1'b0;
  logic       enemy_killed = 1'b0;
  logic       player_hit = 1'b0;
`ifdef GAME_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic [3:0] level;
  logic       level_change;
  logic [1:0] lives;
  logic [2:0] state;
  logic       play_en;
  logic       freeze;

  int errors = 0;
  int checks = 0;
  int lc_count = 0;
  logic lc_prev = 1'b0;

  game_sequencer dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .start(start),
    .enemy_killed(enemy_killed), .player_hit(player_hit),
`ifdef GAME_PAUSE_EN
    .pause(pause),
`endif
    .level(level), .level_change(level_change), .lives(lives),
    .state(state), .play_en(play_en), .freeze(freeze)
  );

  always #5 pclk = ~pclk;

  // Counts level_change pulses and flags back-to-back assertion.
  always @(posedge pclk) begin
    #2;
    if (level_change) begin
      lc_count++;
      if (lc_prev) begin
        errors++;
        $display("FAIL lc_back_to_back: level_change high %0d cycles running, required 1", 2);
      end
    end
    lc_prev = level_change;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Full output check against an expected state/level/lives/pulse count.
  task automatic chk_all(input string nm, input game_state_e s, input int lv, input int lf, input int lc);
    chk({nm, " state"}, 32'(state), 32'(s));
    chk({nm, " level"}, 32'(level), lv);
    chk({nm, " lives"}, 32'(lives), lf);
    chk({nm, " lc_count"}, lc_count, lc);
    chk({nm, " play_en"}, 32'(play_en), 32'(s == PLAY));
    chk({nm, " freeze"}, 32'(freeze), 32'(s != PLAY));
  endtask

  task automatic press_start();
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    @(negedge pclk);
  endtask

  task automatic pulse_in(input logic kl, input logic ht);
    enemy_killed = kl;
    player_hit   = ht;
    @(negedge pclk);
    enemy_killed = 1'b0;
    player_hit   = 1'b0;
  endtask

  task automatic frame();
    vsync_in = 1'b1;
    @(negedge pclk);
    vsync_in = 1'b0;
    @(negedge pclk);
  endtask

  typedef struct {
    bit          st;
    bit          kl;
    bit          ht;
    int          frames;
    game_state_e est;
    int          elv;
    int          elf;
    int          elc;
  } vec_t;

  localparam int NV = 24;
  vec_t vt[NV];

  function automatic vec_t mk(bit st, bit kl, bit ht, int fr, game_state_e s, int lv, int lf, int lc);
    vec_t v;
    v.st = st; v.kl = kl; v.ht = ht; v.frames = fr;
    v.est = s; v.elv = lv; v.elf = lf; v.elc = lc;
    return v;
  endfunction

  initial begin
    //            st kl ht frames  state  lvl lives lc
    vt[0]  = mk(1, 0, 0, 0,   PLAY,  1, 3, 1);  // start loads level 1
    vt[1]  = mk(0, 1, 0, 0,   PLAY,  1, 3, 1);  // kill 1
    vt[2]  = mk(0, 1, 0, 0,   PLAY,  1, 3, 1);  // kill 2
    vt[3]  = mk(0, 1, 0, 0,   PLAY,  1, 3, 1);  // kill 3
    vt[4]  = mk(0, 1, 0, 0,   PLAY,  1, 3, 1);  // kill 4
    vt[5]  = mk(0, 1, 1, 0,   HIT,   1, 2, 1);  // hit beats kill
    vt[6]  = mk(0, 0, 1, 0,   HIT,   1, 2, 1);  // invulnerable
    vt[7]  = mk(0, 0, 0, 59,  HIT,   1, 2, 1);  // one tick short
    vt[8]  = mk(0, 0, 0, 1,   PLAY,  1, 2, 1);  // 60th tick
    vt[9]  = mk(0, 1, 0, 0,   CLEAR, 1, 2, 1);  // kills kept at 4 -> 5th clears
    vt[10] = mk(0, 1, 1, 0,   CLEAR, 1, 2, 1);  // ignored in CLEAR
    vt[11] = mk(0, 0, 0, 119, CLEAR, 1, 2, 1);
    vt[12] = mk(0, 0, 0, 1,   PLAY,  2, 2, 2);  // 120th tick advances
    vt[13] = mk(1, 0, 0, 0,   PLAY,  2, 2, 2);  // start ignored in PLAY
    vt[14] = mk(0, 0, 1, 0,   HIT,   2, 1, 2);
    vt[15] = mk(0, 0, 0, 60,  PLAY,  2, 1, 2);
    vt[16] = mk(0, 0, 1, 0,   OVER,  2, 0, 2);  // last life
    vt[17] = mk(0, 0, 1, 0,   OVER,  2, 0, 2);  // no underflow
    vt[18] = mk(1, 0, 0, 0,   PLAY,  1, 3, 3);  // restart
    vt[19] = mk(0, 0, 1, 60,  PLAY,  1, 2, 3);  // hit 1, full HIT window
    vt[20] = mk(0, 0, 1, 60,  PLAY,  1, 1, 3);  // hit 2
    vt[21] = mk(0, 0, 1, 0,   OVER,  1, 0, 3);  // hit 3
    vt[22] = mk(1, 0, 0, 0,   PLAY,  1, 3, 4);
    vt[23] = mk(0, 0, 1, 59,  HIT,   1, 2, 4);

    // Reset state, both during and after reset.
    repeat (3) @(negedge pclk);
    chk_all("reset_held", IDLE, 1, 3, 0);
    rst = 1'b1;
    repeat (4) @(negedge pclk);
    chk_all("reset_idle", IDLE, 1, 3, 0);

    for (int i = 0; i < NV; i++) begin
      if (vt[i].st) press_start();
      if (vt[i].kl || vt[i].ht) pulse_in(vt[i].kl, vt[i].ht);
      repeat (vt[i].frames) frame();
      chk_all($sformatf("vec%0d", i), vt[i].est, vt[i].elv, vt[i].elf, vt[i].elc);
    end
    frame();
    chk_all("vec23_exit", PLAY, 1, 2, 4);

    // Clear all eight levels.
    press_start();  // ignored: still in PLAY
    for (int lv = 1; lv <= 8; lv++) begin
      repeat (5) pulse_in(1'b1, 1'b0);
      chk_all($sformatf("lvl%0d_clear", lv), CLEAR, lv, 2, 4 + lv - 1);
      repeat (120) frame();
      if (lv < 8) chk_all($sformatf("lvl%0d_next", lv), PLAY, lv + 1, 2, 4 + lv);
      else        chk_all("lvl8_win", WIN, 8, 2, 11);
    end
    repeat (3) pulse_in(1'b1, 1'b1);
    repeat (3) frame();
    chk_all("win_hold", WIN, 8, 2, 11);
    press_start();
    chk_all("win_restart", PLAY, 1, 3, 12);

    // Asynchronous reset in the middle of CLEAR.
    repeat (5) pulse_in(1'b1, 1'b0);
    repeat (10) frame();
    chk_all("pre_rst_clear", CLEAR, 1, 3, 12);
    #1 rst = 1'b0;
    #1;
    chk_all("async_rst", IDLE, 1, 3, 12);
    @(negedge pclk);
    rst = 1'b1;
    repeat (2) @(negedge pclk);
    chk_all("post_rst", IDLE, 1, 3, 12);

`ifdef GAME_PAUSE_EN
    press_start();
    repeat (4) pulse_in(1'b1, 1'b0);
    pause = 1'b1;
    @(negedge pclk);
    pause = 1'b0;
    @(negedge pclk);
    chk_all("pause_enter", PAUSED, 1, 3, 13);
    pulse_in(1'b1, 1'b1);
    repeat (2) frame();
    chk_all("pause_hold", PAUSED, 1, 3, 13);
    pause = 1'b1;
    @(negedge pclk);
    pause = 1'b0;
    @(negedge pclk);
    chk_all("pause_exit", PLAY, 1, 3, 13);
    pulse_in(1'b1, 1'b0);
    chk_all("pause_kills_kept", CLEAR, 1, 3, 13);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
